ds_reg_bank: RTL and testbench
==============================

# ds_reg_bank

Parametrised bank of general-purpose registers for the down-sampling processor datapath. It generalises the single fixed-width swap register into DEPTH registers of WIDTH bits. Each register can be loaded from the datapath bus, incremented or decremented, cleared, copied, or swapped with another register. The control unit drives one operation per cycle, and the bank presents a combinational read port, all register contents, and status flags back to the datapath.

## Interface
- WIDTH, 18, bits per register.
- DEPTH, 4, number of registers; any value 2..16.
- AW, 2, address width; must satisfy 2^AW >= DEPTH.
- RST_VAL, 6, value loaded into every register on reset.

- clk  in  1  bank clock; all state updates on the falling edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  operation enable; op is ignored when low.
- op  in  3  operation code (see Operation).
- wa  in  AW  destination register address.
- sa  in  AW  source register address (COPY, SWAP).
- din  in  WIDTH  datapath bus value (LOAD).
- ra  in  AW  read address.
- dout  out  WIDTH  reg[ra], combinational.
- zero  out  1  high when dout == 0, combinational.
- q_all  out  DEPTH*WIDTH  all registers; reg[i] occupies bits [i*WIDTH +: WIDTH].
- wrap  out  1  registered one-cycle pulse: the last INC/DEC wrapped.
- err  out  1  registered one-cycle pulse: the last enabled op used an address >= DEPTH.
- ovf  out  1  sticky; set on any wrap, cleared only by rst.

## Operation
- op codes:
  - 0 NOP.
  - 1 LOAD: reg[wa] <= din.
  - 2 INC: reg[wa] <= reg[wa]+1, modulo 2^WIDTH.
  - 3 DEC: reg[wa] <= reg[wa]-1, modulo 2^WIDTH.
  - 4 CLR: reg[wa] <= 0.
  - 5 COPY: reg[wa] <= reg[sa].
  - 6 SWAP: reg[wa] and reg[sa] exchange values in the same edge.
  - 7 reserved: treated as NOP; does not raise err.
- Reset behaviour:
  - rst has priority over en and op.
  - On reset: every register = RST_VAL truncated to WIDTH; wrap = 0; err = 0; ovf = 0.
- When en = 0, all registers hold their values, and wrap and err are 0 at the next edge.
- Wrap conditions:
  - INC of all-ones gives 0, sets wrap = 1 and sets ovf.
  - DEC of 0 gives all-ones, sets wrap = 1 and sets ovf.
- Address check:
  - The addresses checked per op are: wa for LOAD/INC/DEC/CLR; wa and sa for COPY/SWAP.
  - If any checked address is >= DEPTH, no register changes and err = 1.
  - An out-of-range ra returns dout = 0 and zero = 1. It is not an error.
- SWAP or COPY with wa == sa: no register changes, no flag is raised.
- Only the addressed register(s) change; all others hold.
- Arithmetic is unsigned and purely width-WIDTH. There is no saturation.

## Timing
- All sequential updates, including rst sampling, occur on the negedge of clk.
  - The control unit changes en/op/wa/sa/din on posedge; they must be stable at the following negedge.
- Write-to-read latency:
  - dout, zero and q_all reflect the new values immediately after the updating negedge.
  - A posedge consumer therefore sees the result half a cycle later.
- wrap and err are valid from the updating negedge until the next negedge (one full clk period), then clear unless re-triggered.
- Read-during-write: before the negedge, dout shows the old value. There is no bypass of din.
- Back-to-back ops on the same register are legal every cycle. Each op uses the value present at its own edge.
- rst asserted mid-sequence (e.g. between two SWAPs) discards the pending op. Registers show RST_VAL after that negedge.

## Test plan
- Reset:
  - Stimulus: hold rst for 2 negedges with en=1, op=LOAD, din=18'h3FFFF.
  - Required: all four regs = 6, q_all = {4{18'd6}}, wrap = err = ovf = 0.
- LOAD, SWAP and same-register SWAP:
  - Stimulus: LOAD reg1 = 100, LOAD reg2 = 7, SWAP wa=1 sa=2.
  - Required after SWAP: reg1 = 7, reg2 = 100; reg0 and reg3 remain 6; ra=2 gives dout = 100.
  - Stimulus: SWAP wa=2 sa=2. Required: reg2 still 100, no flags.
- Wrap:
  - Stimulus: LOAD reg0 = 18'h3FFFF, then INC reg0.
  - Required: reg0 = 0, zero = 1 at ra=0, wrap high for exactly one period, ovf = 1.
  - Stimulus: DEC reg0. Required: reg0 = 18'h3FFFF, ovf still 1.
- Address range:
  - Stimulus: DEPTH=3, AW=2; LOAD wa=3 din=55.
  - Required: no register changes, err pulses once, ovf unchanged.
  - Stimulus: ra=3. Required: dout = 0.
- Enable and reserved op:
  - Stimulus: en=0 with op=CLR wa=1 for 3 cycles, then en=1 with op=7.
  - Required: reg1 unchanged throughout, no flags.
- Reset mid-operation:
  - Stimulus: assert rst at the same negedge as COPY wa=3 sa=1, with reg1 = 9.
  - Required: reg3 = 6 (not 9), all flags cleared.

Source files
------------

// File: rtl/ds_reg_bank_if.sv
// Bus between the datapath control unit and the register bank: operation request,
// read port, register snapshot and status flags.
interface ds_reg_bank_if #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int AW    = 2
);
    logic                   en;
    logic [2:0]             op;
    logic [AW-1:0]          wa;
    logic [AW-1:0]          sa;
    logic [WIDTH-1:0]       din;
    logic [AW-1:0]          ra;
    logic [WIDTH-1:0]       dout;
    logic                   zero;
    logic [DEPTH*WIDTH-1:0] q_all;
    logic                   wrap;
    logic                   err;
    logic                   ovf;

    modport master (
        output en, op, wa, sa, din, ra,
        input  dout, zero, q_all, wrap, err, ovf
    );

    modport slave (
        input  en, op, wa, sa, din, ra,
        output dout, zero, q_all, wrap, err, ovf
    );
endinterface

// File: rtl/ds_reg_bank.sv
// DEPTH x WIDTH general-purpose register bank for the down-sampling datapath.
// One op per cycle, state updated on the falling clock edge, combinational read port.
module ds_reg_bank #(
    parameter int             WIDTH   = 18,
    parameter int             DEPTH   = 4,
    parameter int             AW      = 2,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(6)
) (
    input  logic          clk,
    input  logic          rst,
    ds_reg_bank_if.slave  bus
);
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_CLR  = 3'd4,
        OP_COPY = 3'd5,
        OP_SWAP = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    localparam int NA = 2 ** AW;

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    // Full address-space view: slots beyond DEPTH read as zero and are flagged invalid.
    logic [NA-1:0][WIDTH-1:0]    ext;
    logic [NA-1:0]               addr_ok;

    for (genvar i = 0; i < NA; i++) begin : g_ext
        if (i < DEPTH) begin : g_real
            assign ext[i]     = regs[i];
            assign addr_ok[i] = 1'b1;
        end else begin : g_hole
            assign ext[i]     = '0;
            assign addr_ok[i] = 1'b0;
        end
    end

    op_e              op;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] a_val;
    logic             active;
    logic             need_sa;
    logic             bad;
    logic             same;
    logic             go;
    logic             wrap_n;
    logic             wrap_q;
    logic             err_q;
    logic             ovf_q;

    assign op  = op_e'(bus.op);
    assign cur = ext[bus.wa];
    assign src = ext[bus.sa];

    always_comb begin
        active  = 1'b0;
        need_sa = 1'b0;
        a_val   = cur;
        wrap_n  = 1'b0;
        case (op)
            OP_LOAD: begin active = 1'b1; a_val = bus.din; end
            OP_INC:  begin active = 1'b1; a_val = cur + 1'b1; wrap_n = (cur == '1); end
            OP_DEC:  begin active = 1'b1; a_val = cur - 1'b1; wrap_n = (cur == '0); end
            OP_CLR:  begin active = 1'b1; a_val = '0; end
            OP_COPY: begin active = 1'b1; need_sa = 1'b1; a_val = src; end
            OP_SWAP: begin active = 1'b1; need_sa = 1'b1; a_val = src; end
            default: ;
        endcase
        active = active && bus.en;
        bad    = active && (!addr_ok[bus.wa] || (need_sa && !addr_ok[bus.sa]));
        // A copy/swap onto itself is a no-op rather than a write of the same value.
        same   = need_sa && (bus.wa == bus.sa);
        go     = active && !bad && !same;
        wrap_n = wrap_n && go;
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            // Swap writes both ends from values sampled before the edge.
            for (int i = 0; i < DEPTH; i++) begin
                if (go && bus.wa == AW'(i))
                    regs[i] <= a_val;
                else if (go && op == OP_SWAP && bus.sa == AW'(i))
                    regs[i] <= cur;
            end
            wrap_q <= wrap_n;
            err_q  <= bad;
            ovf_q  <= ovf_q | wrap_n;
        end
    end

    assign bus.dout  = ext[bus.ra];
    assign bus.zero  = (ext[bus.ra] == '0);
    assign bus.q_all = regs;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_ds_reg_bank.sv
// Directed bench for ds_reg_bank: a DEPTH=4 and a DEPTH=3 bank share one stimulus
// stream; an abstract model is compared every cycle, plus hand-computed literals.
module tb_ds_reg_bank;
    localparam int W = 18;
    localparam int MOD = 262144;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [2:0] op;
    logic [1:0] wa, sa, ra;
    logic [W-1:0] din;

    always #5 clk = ~clk;

    ds_reg_bank_if #(.WIDTH(W), .DEPTH(4), .AW(2)) b4 ();
    ds_reg_bank_if #(.WIDTH(W), .DEPTH(3), .AW(2)) b3 ();

    assign b4.en = en;  assign b4.op = op;  assign b4.wa = wa;
    assign b4.sa = sa;  assign b4.din = din; assign b4.ra = ra;
    assign b3.en = en;  assign b3.op = op;  assign b3.wa = wa;
    assign b3.sa = sa;  assign b3.din = din; assign b3.ra = ra;

    ds_reg_bank #(.WIDTH(W), .DEPTH(4), .AW(2), .RST_VAL(18'd6)) u4 (
        .clk(clk), .rst(rst), .bus(b4));
    ds_reg_bank #(.WIDTH(W), .DEPTH(3), .AW(2), .RST_VAL(18'd6)) u3 (
        .clk(clk), .rst(rst), .bus(b3));

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Abstract model: integer registers, modulo arithmetic, flags per bank.
    int dep [2] = '{4, 3};
    int m [2][4];
    bit m_wrap [2];
    bit m_err [2];
    bit m_ovf [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) m[k][i] = 6;
                m_wrap[k] = 0; m_err[k] = 0; m_ovf[k] = 0;
            end else begin
                m_wrap[k] = 0; m_err[k] = 0;
                if (en && op >= 1 && op <= 6) begin
                    if (int'(wa) >= dep[k] || ((op == 5 || op == 6) && int'(sa) >= dep[k])) begin
                        m_err[k] = 1;
                    end else begin
                        case (op)
                            1: m[k][wa] = int'(din);
                            2: begin
                                if (m[k][wa] == MOD - 1) m_wrap[k] = 1;
                                m[k][wa] = (m[k][wa] + 1) % MOD;
                            end
                            3: begin
                                if (m[k][wa] == 0) m_wrap[k] = 1;
                                m[k][wa] = (m[k][wa] + MOD - 1) % MOD;
                            end
                            4: m[k][wa] = 0;
                            5: m[k][wa] = m[k][sa];
                            6: begin
                                int t;
                                t = m[k][wa];
                                m[k][wa] = m[k][sa];
                                m[k][sa] = t;
                            end
                            default: ;
                        endcase
                    end
                    if (m_wrap[k]) m_ovf[k] = 1;
                end
            end
        end
    end

    function automatic logic [71:0] exp_q(input int k);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < dep[k]; i++) r[i*W +: W] = W'(m[k][i]);
        return r;
    endfunction

    function automatic logic [71:0] exp_dout(input int k);
        if (int'(ra) < dep[k]) return 72'(m[k][ra]);
        return '0;
    endfunction

    always @(posedge clk) begin
        if (chk_on) begin
            chk("d4_q_all", 72'(b4.q_all), exp_q(0));
            chk("d4_dout",  72'(b4.dout),  exp_dout(0));
            chk("d4_zero",  72'(b4.zero),  72'(exp_dout(0) == 0));
            chk("d4_wrap",  72'(b4.wrap),  72'(m_wrap[0]));
            chk("d4_err",   72'(b4.err),   72'(m_err[0]));
            chk("d4_ovf",   72'(b4.ovf),   72'(m_ovf[0]));
            chk("d3_q_all", 72'(b3.q_all), exp_q(1));
            chk("d3_dout",  72'(b3.dout),  exp_dout(1));
            chk("d3_zero",  72'(b3.zero),  72'(exp_dout(1) == 0));
            chk("d3_wrap",  72'(b3.wrap),  72'(m_wrap[1]));
            chk("d3_err",   72'(b3.err),   72'(m_err[1]));
            chk("d3_ovf",   72'(b3.ovf),   72'(m_ovf[1]));
        end
    end

    // Drive at posedge+1, let the negedge apply it, return at the next posedge+1.
    task automatic step(input logic e, input logic [2:0] o, input logic [1:0] w,
                        input logic [1:0] s, input logic [W-1:0] d);
        en = e; op = o; wa = w; sa = s; din = d;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] r4(input int i);
        return b4.q_all[i*W +: W];
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; op = 3'd1; wa = 2'd0; sa = 2'd0;
        din = 18'h3FFFF; ra = 2'd0;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("rst_q4", 72'(b4.q_all), 72'({4{18'd6}}));
        chk("rst_q3", 72'(b3.q_all), 72'({3{18'd6}}));
        chk("rst_flags", 72'({b4.wrap, b4.err, b4.ovf, b3.wrap, b3.err, b3.ovf}), 72'(0));
        rst = 1'b0;

        step(1, 3'd1, 2'd1, 2'd0, 18'd100);
        step(1, 3'd1, 2'd2, 2'd0, 18'd7);
        step(1, 3'd6, 2'd1, 2'd2, 18'd0);
        chk("swap_r1", 72'(r4(1)), 72'd7);
        chk("swap_r2", 72'(r4(2)), 72'd100);
        chk("swap_r0r3", 72'({r4(0), r4(3)}), 72'({18'd6, 18'd6}));
        ra = 2'd2; #1;
        chk("swap_dout", 72'(b4.dout), 72'd100);
        step(1, 3'd6, 2'd2, 2'd2, 18'd0);
        chk("self_swap_r2", 72'(r4(2)), 72'd100);
        chk("self_swap_flags", 72'({b4.wrap, b4.err}), 72'(0));

        step(1, 3'd1, 2'd0, 2'd0, 18'h3FFFF);
        step(1, 3'd2, 2'd0, 2'd0, 18'd0);
        ra = 2'd0; #1;
        chk("inc_r0", 72'(r4(0)), 72'd0);
        chk("inc_zero", 72'(b4.zero), 72'd1);
        chk("inc_wrap", 72'(b4.wrap), 72'd1);
        chk("inc_ovf", 72'(b4.ovf), 72'd1);
        step(1, 3'd0, 2'd0, 2'd0, 18'd0);
        chk("wrap_cleared", 72'(b4.wrap), 72'd0);
        step(1, 3'd3, 2'd0, 2'd0, 18'd0);
        chk("dec_r0", 72'(r4(0)), 72'h3FFFF);
        chk("dec_ovf", 72'(b4.ovf), 72'd1);

        step(1, 3'd1, 2'd3, 2'd0, 18'd55);
        chk("oor_err3", 72'(b3.err), 72'd1);
        chk("oor_q3", 72'(b3.q_all), 72'({18'd100, 18'd7, 18'h3FFFF}));
        chk("oor_ovf3", 72'(b3.ovf), 72'd1);
        chk("ok_r3_d4", 72'(r4(3)), 72'd55);
        step(1, 3'd0, 2'd0, 2'd0, 18'd0);
        chk("oor_err3_once", 72'(b3.err), 72'd0);
        ra = 2'd3; #1;
        chk("oor_dout3", 72'(b3.dout), 72'd0);
        chk("oor_zero3", 72'(b3.zero), 72'd1);
        chk("ra3_dout4", 72'(b4.dout), 72'd55);
        step(1, 3'd5, 2'd0, 2'd3, 18'd0);

        for (int i = 0; i < 3; i++) begin
            step(0, 3'd4, 2'd1, 2'd0, 18'd0);
            chk("en0_r1", 72'(r4(1)), 72'd7);
        end
        step(1, 3'd7, 2'd1, 2'd0, 18'd0);
        chk("rsvd_r1", 72'(r4(1)), 72'd7);
        chk("rsvd_flags", 72'({b4.wrap, b4.err, b3.wrap, b3.err}), 72'(0));

        step(1, 3'd2, 2'd1, 2'd0, 18'd0);
        step(1, 3'd2, 2'd1, 2'd0, 18'd0);
        chk("b2b_inc_r1", 72'(r4(1)), 72'd9);
        rst = 1'b1;
        step(1, 3'd5, 2'd3, 2'd1, 18'd0);
        chk("rst_mid_r3", 72'(r4(3)), 72'd6);
        chk("rst_mid_flags", 72'({b4.wrap, b4.err, b4.ovf}), 72'(0));
        rst = 1'b0;
        step(1, 3'd0, 2'd0, 2'd0, 18'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
